sd_spi_router: RTL and testbench

//  Routes the core's single SPI master to one physical SD card or one of NUM_VSD virtual (image-backed) card slots.

---
 rtl/sd_router_pkg.sv | 10 +
 rtl/sd_act_timer.sv | 45 ++++
 rtl/sd_spi_router.sv | 134 +++++++++++++
 tb/tb_sd_spi_router.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/sd_router_pkg.sv
// Shared constants and helpers for the SD SPI router.
package sd_router_pkg;
  localparam int SEL_PHYS        = 0;
  localparam int ACT_TIMEOUT_DEF = 1000000;
  localparam int IDLE_CYCLES_DEF = 2;

  function automatic int sel_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sd_act_timer.sv
// Per-channel activity detector: MOSI/MISO edge restarts a saturating timer.
module sd_act_timer
  import sd_router_pkg::*;
#(
  parameter int ACT_TIMEOUT = ACT_TIMEOUT_DEF,
  localparam int TW = (ACT_TIMEOUT < 1) ? 1 : $clog2(ACT_TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic mosi,
  input  logic miso,
  output logic act
);
  localparam logic [TW-1:0] MAX = TW'(ACT_TIMEOUT);

  logic          mosi_q;
  logic          miso_q;
  logic          edge_det;
  logic [TW-1:0] timer_d;
  logic [TW-1:0] timer_q;

  always_comb begin
    edge_det = (mosi ^ mosi_q) | (miso ^ miso_q);
    timer_d  = timer_q;
    if (en && edge_det) begin
      timer_d = '0;
    end else if (timer_q < MAX) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Data samples track through reset so no false edge follows it.
  always_ff @(posedge clk) begin
    mosi_q <= mosi;
    miso_q <= miso;
    if (reset) begin
      timer_q <= MAX;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign act = (timer_q < MAX);
endmodule

// File: rtl/sd_spi_router.sv
// Routes one SPI master to the physical SD card or one of NUM_VSD virtual slots.
// SD_ROUTER_HOTSWAP_EN: unmount falls back to highest still-mounted slot.
module sd_spi_router
  import sd_router_pkg::*;
#(
  parameter int NUM_VSD     = 1,
  parameter int ACT_TIMEOUT = ACT_TIMEOUT_DEF,
  parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
  localparam int CW = sel_w(NUM_VSD)
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic [NUM_VSD-1:0] img_mounted,
  input  logic [NUM_VSD-1:0] img_nonzero,
  input  logic               spi_sck,
  input  logic               spi_mosi,
  input  logic               spi_ss_n,
  output logic               spi_miso,
  output logic               sd_cs_n,
  output logic               sd_sck,
  output logic               sd_mosi,
  input  logic               sd_miso,
  output logic [NUM_VSD-1:0] vsd_ss_n,
  input  logic [NUM_VSD-1:0] vsd_miso,
  output logic [CW-1:0]      sel,
  output logic [NUM_VSD:0]   act,
  output logic               led_phys,
  output logic               led_virt
);
  localparam int IW = (IDLE_CYCLES < 1) ? 1 : $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);

  logic [CW-1:0]      sel_d, sel_q;
  logic [CW-1:0]      pending_d, pending_q;
  logic [NUM_VSD-1:0] mounted_d, mounted_q;
  logic [IW-1:0]      idle_d, idle_q;
  logic [NUM_VSD-1:0] mnt, umnt;
  logic [CW-1:0]      fallback;
  logic               drop;
  logic               miso_sel;
  logic [NUM_VSD:0]   ch_miso;
  logic [NUM_VSD:0]   ch_en;

  assign mnt  = img_mounted & img_nonzero;
  assign umnt = img_mounted & ~img_nonzero;

  // Unmounts resolve first; a mount in the same cycle overrides pending.
  always_comb begin
    mounted_d = mounted_q & ~umnt;
    pending_d = pending_q;
    drop      = 1'b0;
    fallback  = CW'(SEL_PHYS);
    for (int k = 0; k < NUM_VSD; k++) begin
      if (umnt[k] && (pending_q == CW'(k + 1) || sel_q == CW'(k + 1))) begin
        drop = 1'b1;
      end
`ifdef SD_ROUTER_HOTSWAP_EN
      if (mounted_d[k]) begin
        fallback = CW'(k + 1);
      end
`endif
    end
    if (drop) begin
      pending_d = fallback;
    end
    for (int k = 0; k < NUM_VSD; k++) begin
      if (mnt[k]) begin
        pending_d = CW'(k + 1);
      end
    end
    mounted_d = mounted_d | mnt;
  end

  always_comb begin
    idle_d = '0;
    if (spi_ss_n) begin
      idle_d = (idle_q < IDLE_MAX) ? idle_q + 1'b1 : idle_q;
    end
    sel_d = sel_q;
    if (spi_ss_n && idle_q >= IDLE_MAX && pending_q != sel_q) begin
      sel_d = pending_q;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sel_q     <= CW'(SEL_PHYS);
      pending_q <= CW'(SEL_PHYS);
      mounted_q <= '0;
      idle_q    <= '0;
    end else begin
      sel_q     <= sel_d;
      pending_q <= pending_d;
      mounted_q <= mounted_d;
      idle_q    <= idle_d;
    end
  end

  always_comb begin
    vsd_ss_n = '1;
    miso_sel = sd_miso;
    for (int k = 0; k < NUM_VSD; k++) begin
      if (sel_q == CW'(k + 1)) begin
        vsd_ss_n[k] = spi_ss_n;
        miso_sel    = vsd_miso[k];
      end
    end
  end

  assign sd_cs_n  = (sel_q == CW'(SEL_PHYS)) ? spi_ss_n : 1'b1;
  assign sd_sck   = spi_sck & ~sd_cs_n;
  assign sd_mosi  = spi_mosi & ~sd_cs_n;
  assign spi_miso = reset ? 1'b1 : miso_sel;
  assign sel      = sel_q;

  assign ch_miso = {vsd_miso, sd_miso};

  for (genvar c = 0; c <= NUM_VSD; c++) begin : g_act
    assign ch_en[c] = (sel_q == CW'(c)) & ~spi_ss_n;
    sd_act_timer #(
      .ACT_TIMEOUT(ACT_TIMEOUT)
    ) u_timer (
      .clk  (clk_sys),
      .reset(reset),
      .en   (ch_en[c]),
      .mosi (spi_mosi),
      .miso (ch_miso[c]),
      .act  (act[c])
    );
  end

  assign led_phys = act[0];
  assign led_virt = |act[NUM_VSD:1];
endmodule

// File: tb/tb_sd_spi_router.sv
// Directed bench for sd_spi_router (NUM_VSD=2, ACT_TIMEOUT=16, IDLE_CYCLES=2).
module tb_sd_spi_router;
  logic       clk_sys = 1'b0;
  logic       reset;
  logic [1:0] img_mounted;
  logic [1:0] img_nonzero;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_ss_n;
  logic       spi_miso;
  logic       sd_cs_n;
  logic       sd_sck;
  logic       sd_mosi;
  logic       sd_miso;
  logic [1:0] vsd_ss_n;
  logic [1:0] vsd_miso;
  logic [1:0] sel;
  logic [2:0] act;
  logic       led_phys;
  logic       led_virt;

  int n_cmp = 0;
  int n_bad = 0;

  sd_spi_router #(
    .NUM_VSD    (2),
    .ACT_TIMEOUT(16),
    .IDLE_CYCLES(2)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .img_mounted(img_mounted),
    .img_nonzero(img_nonzero),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_ss_n   (spi_ss_n),
    .spi_miso   (spi_miso),
    .sd_cs_n    (sd_cs_n),
    .sd_sck     (sd_sck),
    .sd_mosi    (sd_mosi),
    .sd_miso    (sd_miso),
    .vsd_ss_n   (vsd_ss_n),
    .vsd_miso   (vsd_miso),
    .sel        (sel),
    .act        (act),
    .led_phys   (led_phys),
    .led_virt   (led_virt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int w;
    reset       = 1'b1;
    img_mounted = 2'b00;
    img_nonzero = 2'b00;
    spi_sck     = 1'b0;
    spi_mosi    = 1'b0;
    spi_ss_n    = 1'b1;
    sd_miso     = 1'b0;
    vsd_miso    = 2'b01;
    tick(2);
    chk("rst_miso", 32'(spi_miso), 32'd1);
    reset = 1'b0;
    tick(1);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_cs", 32'(sd_cs_n), 32'd1);
    chk("rst_vss", 32'(vsd_ss_n), 32'b11);
    chk("rst_act", 32'(act), 32'd0);

    // Physical path follows the master.
    spi_ss_n = 1'b0;
    spi_sck  = 1'b1;
    #1;
    chk("phys_cs", 32'(sd_cs_n), 32'd0);
    chk("phys_sck", 32'(sd_sck), 32'd1);
    chk("phys_miso", 32'(spi_miso), 32'd0);
    spi_ss_n = 1'b1;
    spi_sck  = 1'b0;
    tick(3);

    // Mount slot1 while idle.
    img_mounted = 2'b10;
    img_nonzero = 2'b10;
    tick(1);
    img_mounted = 2'b00;
    img_nonzero = 2'b00;
    w = 0;
    while (sel !== 2'd2 && w < 3) begin
      tick(1);
      w++;
    end
    chk("m1_sel", 32'(sel), 32'd2);
    spi_ss_n = 1'b0;
    spi_sck  = 1'b1;
    #1;
    chk("m1_vss", 32'(vsd_ss_n), 32'b01);
    chk("m1_cs", 32'(sd_cs_n), 32'd1);
    chk("m1_sck", 32'(sd_sck), 32'd0);
    chk("m1_miso", 32'(spi_miso), 32'd0);

    // One MOSI edge on slot1.
    spi_mosi = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      chk("act_hi", 32'(act[2]), 32'd1);
    end
    chk("led_virt_hi", 32'(led_virt), 32'd1);
    chk("led_phys_lo", 32'(led_phys), 32'd0);
    tick(1);
    chk("act_lo", 32'(act[2]), 32'd0);
    chk("led_virt_lo", 32'(led_virt), 32'd0);

    spi_ss_n = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    tick(3);

    // Mount slot0 mid-transaction: switch deferred.
    spi_ss_n = 1'b0;
    tick(1);
    img_mounted = 2'b01;
    img_nonzero = 2'b01;
    tick(1);
    img_mounted = 2'b00;
    img_nonzero = 2'b00;
    tick(40);
    chk("busy_sel", 32'(sel), 32'd2);
    spi_ss_n = 1'b1;
    tick(1);
    chk("idle1_sel", 32'(sel), 32'd2);
    tick(1);
    chk("idle2_sel", 32'(sel), 32'd2);
    tick(1);
    chk("idle3_sel", 32'(sel), 32'd1);

    // Simultaneous mounts: highest slot wins.
    img_mounted = 2'b11;
    img_nonzero = 2'b11;
    tick(1);
    img_mounted = 2'b00;
    img_nonzero = 2'b00;
    chk("sim_pre", 32'(sel), 32'd1);
    tick(1);
    chk("sim_sel", 32'(sel), 32'd2);

    // Unmount selected slot1 while slot0 still mounted.
    img_mounted = 2'b10;
    img_nonzero = 2'b00;
    tick(1);
    img_mounted = 2'b00;
    tick(1);
`ifdef SD_ROUTER_HOTSWAP_EN
    chk("unm_sel", 32'(sel), 32'd1);
`else
    chk("unm_sel", 32'(sel), 32'd0);
`endif

    // Reset mid-transaction returns to physical at once.
    img_mounted = 2'b10;
    img_nonzero = 2'b10;
    tick(1);
    img_mounted = 2'b00;
    img_nonzero = 2'b00;
    tick(1);
    chk("re_sel", 32'(sel), 32'd2);
    spi_ss_n = 1'b0;
    reset    = 1'b1;
    tick(1);
    reset = 1'b0;
    #1;
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_cs", 32'(sd_cs_n), 32'd0);
    chk("mid_rst_vss", 32'(vsd_ss_n), 32'b11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
